// File: rtl/pt_decode.sv
// Slot-serial BFV plaintext decoder: gamma[i] = round(T*phase[i]/Q) mod T,
// one restoring-division step per cycle, valid/ready on both sides.
module pt_decode #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 17,
  parameter int unsigned WW = 2 * W,
  parameter int unsigned QP = 65537,
  parameter int unsigned TP = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0][W-1:0]   in_phase,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0][W-1:0]   out_gamma,
  output logic                  busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BW = $clog2(WW + 1);

  localparam logic [W-1:0]  Q_W    = W'(QP);
  localparam logic [W+1:0]  Q_R    = (W+2)'(QP);
  localparam logic [WW:0]   T_N    = (WW+1)'(TP);
  localparam logic [WW:0]   HALF_N = (WW+1)'(QP / 2);
  localparam logic [IW-1:0] LAST   = IW'(N - 1);
  localparam logic [BW-1:0] TOP    = BW'(WW);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_WRITE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [N-1:0][W-1:0]   phase_q, phase_d;
  logic [N-1:0][W-1:0]   out_gamma_q, out_gamma_d;
  logic [IW-1:0]         slot_q, slot_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [WW:0]           num_q, num_d;
  logic [WW:0]           quo_q, quo_d;
  logic [W:0]            rem_q, rem_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;

  logic [W-1:0]          p_raw, p_adj;
  logic [W+1:0]          rem_sh;
  logic                  rem_ge;
  logic [WW:0]           g;

  // Next-state and datapath for the PREP / DIV / WRITE slot loop
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    out_gamma_d = out_gamma_q;
    slot_d      = slot_q;
    bit_d       = bit_q;
    num_d       = num_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    p_raw  = phase_q[slot_q];
    p_adj  = (p_raw >= Q_W) ? (p_raw - Q_W) : p_raw;
    rem_sh = {rem_q, num_q[bit_q]};
    rem_ge = (rem_sh >= Q_R);
    g      = (quo_q >= T_N) ? (quo_q - T_N) : quo_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          phase_d    = in_phase;
          slot_d     = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_PREP;
        end
      end
      S_PREP: begin
        num_d   = T_N * (WW+1)'(p_adj) + HALF_N;
        rem_d   = '0;
        quo_d   = '0;
        bit_d   = TOP;
        state_d = S_DIV;
      end
      S_DIV: begin
        rem_d = rem_ge ? (W+1)'(rem_sh - Q_R) : rem_sh[W:0];
        quo_d = {quo_q[WW-1:0], rem_ge};
        if (bit_q == '0) begin
          state_d = S_WRITE;
        end else begin
          bit_d = bit_q - 1'b1;
        end
      end
      S_WRITE: begin
        out_gamma_d[slot_q] = W'(g);
        if (slot_q == LAST) begin
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          slot_d  = slot_q + 1'b1;
          state_d = S_PREP;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      out_gamma_q <= '0;
      slot_q      <= '0;
      bit_q       <= '0;
      num_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      out_gamma_q <= out_gamma_d;
      slot_q      <= slot_d;
      bit_q       <= bit_d;
      num_q       <= num_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_gamma = out_gamma_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pt_decode.sv
// Scoreboard bench for pt_decode: accepted vectors push a reference result,
// the output monitor pops and compares on each output handshake.
module tb_pt_decode;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 17;
  localparam int unsigned WW  = 34;
  localparam int unsigned QP  = 65537;
  localparam int unsigned TP  = 256;
  localparam int unsigned LAT = N * (WW + 3);

  typedef logic [N-1:0][W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  vec_t in_phase;
  logic out_valid;
  logic out_ready;
  vec_t out_gamma;
  logic busy;

  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   last_acc = 0;
  int   last_hs  = 0;
  logic prev_valid = 1'b0;
  vec_t held;
  vec_t exp_q[$];
  int   acc_q[$];

  pt_decode #(.N(N), .W(W), .WW(WW), .QP(QP), .TP(TP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_phase  (in_phase),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gamma (out_gamma),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: rounded scaling of each phase, reduced into [0, T)
  function automatic vec_t model(input vec_t ph);
    vec_t r;
    longint unsigned p, n;
    for (int i = 0; i < N; i++) begin
      p = longint'(ph[i]);
      if (p >= QP) p = p - QP;
      n = p * TP + QP / 2;
      r[i] = W'((n / QP) % TP);
    end
    return r;
  endfunction

  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = W'(a);
    v[1] = W'(b);
    v[2] = W'(c);
    v[3] = W'(d);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Input-side capture and output-side checking
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_phase));
        acc_q.push_back(cyc + 1);
        last_acc = cyc + 1;
        n_vec++;
      end
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) fail("spurious_valid");
        else chk("latency", 128'(cyc - acc_q.pop_front()), 128'(LAT));
        held = out_gamma;
      end else if (out_valid) begin
        chk("hold_gamma", out_gamma, held);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_busy", busy, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_output");
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          for (int i = 0; i < N; i++) chk($sformatf("gamma[%0d]", i), out_gamma[i], e[i]);
        end
        last_hs = cyc + 1;
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input vec_t v, input bit hold);
    int k;
    in_phase = v;
    in_valid = 1'b1;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 500) fail("accept_timeout");
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid && in_ready) break;
    end
    if (k == 3000) fail("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gamma"}, out_gamma, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t v;
    int   k;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_phase  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic decode: noise around symbols, wrap to zero, max symbol
    send(mk(1797, 65534, 65280, 0), 1'b0);
    wait_idle();
    chk("basic_s0", out_gamma[0], 7);
    chk("basic_s1", out_gamma[1], 0);
    chk("basic_s2", out_gamma[2], 255);
    chk("basic_s3", out_gamma[3], 0);

    // Phase above Q takes the single conditional subtract
    send(mk(0, 0, 67334, 0), 1'b0);
    wait_idle();
    chk("oor_s2", out_gamma[2], 7);
    chk("oor_s0", out_gamma[0], 0);

    // Rounding boundary around the half-step
    send(mk(128, 127, 32768, 32767), 1'b0);
    wait_idle();

    // Backpressure for 20 cycles
    out_ready = 1'b0;
    send(mk(40000, 255, 65536, 1), 1'b0);
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (k == 400) fail("valid_timeout");
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rel_in_ready", in_ready, 1);
    chk("bp_rel_out_valid", out_valid, 0);
    chk("bp_rel_busy", busy, 0);

    // Back-to-back: in_valid held high across busy with a second vector
    send(mk(1000, 2000, 3000, 4000), 1'b1);
    in_phase = mk(60000, 70000, 131071, 33000);
    send(in_phase, 1'b0);
    chk("b2b_gap", 128'(last_acc), 128'(last_hs + 1));
    wait_idle();

    // Reset in the middle of a decode
    send(mk(12345, 54321, 99999, 7), 1'b0);
    repeat (59) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(mk(1797, 65280, 256, 65000), 1'b0);
    wait_idle();
    chk("post_rst_s0", out_gamma[0], 7);

    // Randomized vectors, with some weight on values near 0, Q/2 and Q
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: v[i] = W'($urandom_range(0, 300));
          1: v[i] = W'($urandom_range(QP - 300, QP + 300));
          2: v[i] = W'($urandom_range(QP / 2 - 200, QP / 2 + 200));
          default: v[i] = W'($urandom_range(0, (1 << W) - 1));
        endcase
      end
      send(v, 1'b0);
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
